// File: rtl/insn_queue.sv
`default_nettype none
// ============================================================================
// Package  : insn_queue_pkg
// Purpose  : Packet types shared by the fetch side, the instruction queue and
//            the dispatch side, plus the NOP encoding used on idle lanes.
// Revision : 1.0 - initial release
// ============================================================================
package insn_queue_pkg;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_IB_PACKET;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IB_DP_PACKET;

endpackage

// ============================================================================
// Module   : insn_queue
// Purpose  : In-order instruction queue between fetch (IF) and dispatch (DP).
//            Accepts up to IN_WIDTH packets per cycle (compacting away invalid
//            lanes), presents the OUT_WIDTH oldest entries combinationally and
//            pops a requested count. A ROB squash empties it in one cycle.
// Ports    : clock            - rising-edge clock
//            reset_n          - asynchronous active-low reset
//            squashed_sig_rob - flush all contents (has priority)
//            if_ib_packet     - IN_WIDTH fetch lanes, each with .valid
//            ib_ready         - a full fetch beat will be accepted this cycle
//            dp_packet_req    - number of entries DP consumes this cycle
//            ib_dp_packet     - OUT_WIDTH oldest entries, lane 0 = oldest
//            ib_count         - current occupancy
//            ib_empty         - occupancy is zero
//            ib_full          - occupancy equals DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int IN_WIDTH  = 2,
  parameter  int OUT_WIDTH = 2,
  localparam int CNT_W     = $clog2(DEPTH) + 1,
  localparam int REQ_W     = $clog2(OUT_WIDTH + 1)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             squashed_sig_rob,
  input  insn_queue_pkg::IF_IB_PACKET [IN_WIDTH-1:0]  if_ib_packet,
  output logic                             ib_ready,
  input  logic [REQ_W-1:0]                 dp_packet_req,
  output insn_queue_pkg::IB_DP_PACKET [OUT_WIDTH-1:0] ib_dp_packet,
  output logic [CNT_W-1:0]                 ib_count,
  output logic                             ib_empty,
  output logic                             ib_full
);

  localparam int               IDX_W     = CNT_W - 1;
  localparam int               CMP_W     = CNT_W + REQ_W;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - IN_WIDTH);
  localparam logic [CMP_W-1:0] OUT_MAX   = CMP_W'(OUT_WIDTH);

  // Stored payload; valid is implied by position relative to head/count.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [CNT_W-1:0]  head;
  logic [CNT_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  n_acc;
  logic [CNT_W-1:0]  n_out;
  logic [CNT_W-1:0]  lane_off [IN_WIDTH];
  logic [IDX_W-1:0]  wr_idx   [IN_WIDTH];

  // --------------------------------------------------------------------------
  // Enqueue side: popcount of valid lanes, and for each lane the number of
  // valid lanes below it. That prefix count is the lane's slot offset from
  // tail, which is what squeezes out the invalid holes.
  // --------------------------------------------------------------------------
  always_comb begin
    n_in = '0;
    for (int l = 0; l < IN_WIDTH; l++) begin
      lane_off[l] = n_in;
      wr_idx[l]   = IDX_W'(tail + n_in);
      n_in        = n_in + CNT_W'(if_ib_packet[l].valid);
    end
  end

  // Only the registered count is considered; a same-cycle pop does not free
  // room early, so IF sees a stable ready for the whole cycle.
  assign ib_ready = (count <= READY_MAX);
  assign n_acc    = ib_ready ? n_in : '0;

  // --------------------------------------------------------------------------
  // Dequeue side: clamp the request to what is present and to the port width.
  // Compared in a widened domain so neither operand is truncated.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [CMP_W-1:0] req_x;
    logic [CMP_W-1:0] cnt_x;
    logic [CMP_W-1:0] out_x;
    req_x = CMP_W'(dp_packet_req);
    cnt_x = CMP_W'(count);
    out_x = req_x;
    if (out_x > cnt_x) begin
      out_x = cnt_x;
    end
    if (out_x > OUT_MAX) begin
      out_x = OUT_MAX;
    end
    n_out = CNT_W'(out_x);
  end

  // --------------------------------------------------------------------------
  // Pointer / occupancy state. Squash beats both enqueue and dequeue.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squashed_sig_rob) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_out;
      tail  <= tail + n_acc;
      count <= count + n_acc - n_out;
    end
  end

  // Storage carries no reset; its contents are meaningless outside the
  // head..head+count window.
  always_ff @(posedge clock) begin
    if (ib_ready && !squashed_sig_rob) begin
      for (int l = 0; l < IN_WIDTH; l++) begin
        if (if_ib_packet[l].valid) begin
          mem[wr_idx[l]] <= '{inst: if_ib_packet[l].inst,
                              pc:   if_ib_packet[l].PC,
                              npc:  if_ib_packet[l].NPC};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read side: lane i shows the i-th oldest entry when it exists, otherwise a
  // NOP. Driven straight from registered state, so it is not gated by squash
  // in the squash cycle itself and clears the moment reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < OUT_WIDTH; i++) begin
      logic [IDX_W-1:0] rd_idx;
      rd_idx = IDX_W'(head + CNT_W'(i));
      if (CNT_W'(i) < count) begin
        ib_dp_packet[i].valid = 1'b1;
        ib_dp_packet[i].inst  = mem[rd_idx].inst;
        ib_dp_packet[i].PC    = mem[rd_idx].pc;
        ib_dp_packet[i].NPC   = mem[rd_idx].npc;
      end else begin
        ib_dp_packet[i].valid = 1'b0;
        ib_dp_packet[i].inst  = NOP;
        ib_dp_packet[i].PC    = '0;
        ib_dp_packet[i].NPC   = '0;
      end
    end
  end

  assign ib_count = count;
  assign ib_empty = (count == '0);
  assign ib_full  = (count == DEPTH_C);

endmodule
`default_nettype wire

// File: tb/tb_insn_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_insn_queue
// Purpose  : Self-checking bench for insn_queue (DEPTH=16, 2 in, 2 out).
//            Directed vector table, hand-written corner sequences and a random
//            phase, all also compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_queue;
  import insn_queue_pkg::*;

  localparam int DEPTH     = 16;
  localparam int IN_WIDTH  = 2;
  localparam int OUT_WIDTH = 2;
  localparam int CNT_W     = $clog2(DEPTH) + 1;
  localparam int REQ_W     = $clog2(OUT_WIDTH + 1);

  logic                         clock = 1'b0;
  logic                         reset_n = 1'b0;
  logic                         squashed_sig_rob = 1'b0;
  IF_IB_PACKET [IN_WIDTH-1:0]   if_ib_packet = '0;
  logic                         ib_ready;
  logic [REQ_W-1:0]             dp_packet_req = '0;
  IB_DP_PACKET [OUT_WIDTH-1:0]  ib_dp_packet;
  logic [CNT_W-1:0]             ib_count;
  logic                         ib_empty;
  logic                         ib_full;

  insn_queue #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .squashed_sig_rob (squashed_sig_rob),
    .if_ib_packet     (if_ib_packet),
    .ib_ready         (ib_ready),
    .dp_packet_req    (dp_packet_req),
    .ib_dp_packet     (ib_dp_packet),
    .ib_count         (ib_count),
    .ib_empty         (ib_empty),
    .ib_full          (ib_full)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the queue contents, oldest first.
  IF_IB_PACKET model_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic IF_IB_PACKET mk(input logic [31:0] pc, input logic v);
    IF_IB_PACKET p;
    p.valid = v;
    p.inst  = pc ^ 32'hA5A5_0F0F;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  // Compare every DUT output against the reference model.
  task automatic check_model(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, 64'(ib_count), 64'(sz));
    chk({tag, ".ready"}, 64'(ib_ready), 64'((DEPTH - sz) >= IN_WIDTH));
    chk({tag, ".empty"}, 64'(ib_empty), 64'(sz == 0));
    chk({tag, ".full"},  64'(ib_full),  64'(sz == DEPTH));
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (i < sz) begin
        chk($sformatf("%s.l%0d.valid", tag, i), 64'(ib_dp_packet[i].valid), 64'd1);
        chk($sformatf("%s.l%0d.inst", tag, i),  64'(ib_dp_packet[i].inst),  64'(model_q[i].inst));
        chk($sformatf("%s.l%0d.pc", tag, i),    64'(ib_dp_packet[i].PC),    64'(model_q[i].PC));
        chk($sformatf("%s.l%0d.npc", tag, i),   64'(ib_dp_packet[i].NPC),   64'(model_q[i].NPC));
      end else begin
        chk($sformatf("%s.l%0d.valid", tag, i), 64'(ib_dp_packet[i].valid), 64'd0);
        chk($sformatf("%s.l%0d.inst", tag, i),  64'(ib_dp_packet[i].inst),  64'(NOP));
        chk($sformatf("%s.l%0d.pc", tag, i),    64'(ib_dp_packet[i].PC),    64'd0);
        chk($sformatf("%s.l%0d.npc", tag, i),   64'(ib_dp_packet[i].NPC),   64'd0);
      end
    end
    if (ib_full) chk({tag, ".full_not_ready"}, 64'(ib_ready), 64'd0);
  endtask

  // One clock cycle: drive inputs, advance the model by the queue's rules,
  // then compare just after the edge.
  task automatic step(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1,
                      input int req, input logic sq, input string tag);
    IF_IB_PACKET lanes [2];
    bit          rdy;
    int          npop;
    lanes[0] = mk(pc0, mask[0]);
    lanes[1] = mk(pc1, mask[1]);
    if_ib_packet[0]  = lanes[0];
    if_ib_packet[1]  = lanes[1];
    dp_packet_req    = REQ_W'(req);
    squashed_sig_rob = sq;
    rdy  = (DEPTH - model_q.size()) >= IN_WIDTH;
    npop = req;
    if (npop > model_q.size()) npop = model_q.size();
    if (npop > OUT_WIDTH) npop = OUT_WIDTH;
    @(posedge clock);
    if (sq) begin
      model_q.delete();
    end else begin
      repeat (npop) void'(model_q.pop_front());
      if (rdy) begin
        for (int l = 0; l < 2; l++) if (lanes[l].valid) model_q.push_back(lanes[l]);
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    squashed_sig_rob = 1'b0;
    if_ib_packet     = '0;
    dp_packet_req    = '0;
    model_q.delete();
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  mask;
    logic [31:0] pc0;
    logic [31:0] pc1;
    int          req;
    logic        sq;
    int          e_cnt;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_pc0;
    logic        e_v1;
    logic [31:0] e_pc1;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          next_pc;
    int          exit_pc;
    logic [1:0]  rmask;
    int          rreq;
    logic        rsq;

    // rst mask  pc0         pc1       req sq  cnt rdy v0 pc0     v1 pc1
    vecs[0]  = '{1, 2'b11, 32'h0,      32'h4,    0, 0,  2, 1, 1, 32'h0,  1, 32'h4};
    vecs[1]  = '{0, 2'b11, 32'h8,      32'hC,    0, 0,  4, 1, 1, 32'h0,  1, 32'h4};
    vecs[2]  = '{0, 2'b11, 32'h10,     32'h14,   0, 0,  6, 1, 1, 32'h0,  1, 32'h4};
    vecs[3]  = '{0, 2'b00, 32'h0,      32'h0,    1, 0,  5, 1, 1, 32'h4,  1, 32'h8};
    vecs[4]  = '{1, 2'b10, 32'hDEAD,   32'h10,   0, 0,  1, 1, 1, 32'h10, 0, 32'h0};
    vecs[5]  = '{0, 2'b00, 32'h0,      32'h0,    2, 0,  0, 1, 0, 32'h0,  0, 32'h0};
    vecs[6]  = '{0, 2'b01, 32'h40,     32'hBEEF, 3, 0,  1, 1, 1, 32'h40, 0, 32'h0};
    vecs[7]  = '{1, 2'b11, 32'h20,     32'h24,   0, 0,  2, 1, 1, 32'h20, 1, 32'h24};
    vecs[8]  = '{0, 2'b11, 32'h28,     32'h2C,   2, 1,  0, 1, 0, 32'h0,  0, 32'h0};
    vecs[9]  = '{0, 2'b11, 32'h30,     32'h34,   0, 0,  2, 1, 1, 32'h30, 1, 32'h34};
    vecs[10] = '{0, 2'b11, 32'h38,     32'h3C,   3, 0,  2, 1, 1, 32'h38, 1, 32'h3C};

    // Reset state
    #3;
    chk("rst.count", 64'(ib_count), 64'd0);
    chk("rst.ready", 64'(ib_ready), 64'd1);
    chk("rst.empty", 64'(ib_empty), 64'd1);
    chk("rst.full",  64'(ib_full),  64'd0);
    for (int i = 0; i < OUT_WIDTH; i++) begin
      chk($sformatf("rst.l%0d.valid", i), 64'(ib_dp_packet[i].valid), 64'd0);
      chk($sformatf("rst.l%0d.inst", i),  64'(ib_dp_packet[i].inst),  64'(NOP));
    end
    @(posedge clock); #1;
    do_reset();

    // Directed vector table
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst) do_reset();
      step(vecs[v].mask, vecs[v].pc0, vecs[v].pc1, vecs[v].req, vecs[v].sq, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d.t_count", v), 64'(ib_count), 64'(vecs[v].e_cnt));
      chk($sformatf("vec%0d.t_ready", v), 64'(ib_ready), 64'(vecs[v].e_rdy));
      chk($sformatf("vec%0d.t_v0", v),    64'(ib_dp_packet[0].valid), 64'(vecs[v].e_v0));
      chk($sformatf("vec%0d.t_pc0", v),   64'(ib_dp_packet[0].PC),    64'(vecs[v].e_pc0));
      chk($sformatf("vec%0d.t_v1", v),    64'(ib_dp_packet[1].valid), 64'(vecs[v].e_v1));
      chk($sformatf("vec%0d.t_pc1", v),   64'(ib_dp_packet[1].PC),    64'(vecs[v].e_pc1));
    end

    // Fill to 15: beat refused, pop without credit, then beat accepted
    do_reset();
    step(2'b01, 32'h100, 32'h0, 0, 1'b0, "fill0");
    for (int k = 0; k < 7; k++) step(2'b11, 32'h104 + 8 * k, 32'h108 + 8 * k, 0, 1'b0, "fill");
    chk("fill.count15", 64'(ib_count), 64'd15);
    chk("fill.not_ready", 64'(ib_ready), 64'd0);
    step(2'b11, 32'h200, 32'h204, 0, 1'b0, "drop");
    chk("drop.count15", 64'(ib_count), 64'd15);
    step(2'b11, 32'h200, 32'h204, 2, 1'b0, "pop_no_credit");
    chk("pop.count13", 64'(ib_count), 64'd13);
    chk("pop.lane0", 64'(ib_dp_packet[0].PC), 64'h108);
    step(2'b11, 32'h200, 32'h204, 0, 1'b0, "accept");
    chk("accept.count15", 64'(ib_count), 64'd15);

    // Completely full
    do_reset();
    for (int k = 0; k < 8; k++) step(2'b11, 32'h300 + 8 * k, 32'h304 + 8 * k, 0, 1'b0, "tofull");
    chk("full.count16", 64'(ib_count), 64'd16);
    chk("full.flag", 64'(ib_full), 64'd1);
    chk("full.ready", 64'(ib_ready), 64'd0);

    // Wrap: steady 2-in / 2-out, PCs must exit in strict order
    do_reset();
    step(2'b11, 32'h0, 32'h4, 0, 1'b0, "wpre");
    step(2'b11, 32'h8, 32'hC, 0, 1'b0, "wpre");
    next_pc = 32'h10;
    exit_pc = 0;
    for (int k = 0; k < 40; k++) begin
      chk("wrap.exit0", 64'(ib_dp_packet[0].PC), 64'(exit_pc));
      chk("wrap.exit1", 64'(ib_dp_packet[1].PC), 64'(exit_pc + 4));
      step(2'b11, next_pc, next_pc + 4, 2, 1'b0, "wrap");
      chk("wrap.count", 64'(ib_count), 64'd4);
      exit_pc += 8;
      next_pc += 8;
    end

    // Asynchronous reset pulse in the middle of a cycle
    step(2'b11, 32'h500, 32'h504, 0, 1'b0, "prereset");
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.count", 64'(ib_count), 64'd0);
    chk("areset.empty", 64'(ib_empty), 64'd1);
    chk("areset.v0",    64'(ib_dp_packet[0].valid), 64'd0);
    chk("areset.inst0", 64'(ib_dp_packet[0].inst),  64'(NOP));
    model_q.delete();
    if_ib_packet  = '0;
    dp_packet_req = '0;
    reset_n = 1'b1;
    step(2'b00, 32'h0, 32'h0, 0, 1'b0, "postreset");

    // Random phase against the reference model
    next_pc = 32'h1000;
    for (int k = 0; k < 800; k++) begin
      rmask = 2'($urandom_range(0, 3));
      rreq  = (k % 200 < 60) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      rsq   = ($urandom_range(0, 49) == 0);
      step(rmask, next_pc, next_pc + 4, rreq, rsq, "rnd");
      next_pc += 8;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
